// File: rtl/stump_alu_seq_pkg.sv
// Shared Stump ALU definitions: function codes, flag bit positions and FSM states.
package stump_alu_seq_pkg;

    localparam logic [3:0] FN_ADD  = 4'd0;
    localparam logic [3:0] FN_ADC  = 4'd1;
    localparam logic [3:0] FN_SUB  = 4'd2;
    localparam logic [3:0] FN_SBC  = 4'd3;
    localparam logic [3:0] FN_AND  = 4'd4;
    localparam logic [3:0] FN_OR   = 4'd5;
    localparam logic [3:0] FN_LDST = 4'd6;
    localparam logic [3:0] FN_BCC  = 4'd7;
    localparam logic [3:0] FN_MUL  = 4'd8;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/stump_alu_mul_iter.sv
// Iterative shift-add unsigned multiplier, one partial-product step per cycle.
module stump_alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH:0]       upper_sum;
    logic [2*WIDTH-1:0]   step;

    // Upper half accumulates the multiplicand; lower half shifts out multiplier bits.
    always_comb begin
        upper_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        step      = {upper_sum, acc_q[WIDTH-1:1]};
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        if (start_i) begin
            mcand_d = a_i;
            acc_d   = {{WIDTH{1'b0}}, b_i};
            cnt_d   = CW'(WIDTH);
        end else if (cnt_q != '0) begin
            acc_d = step;
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
        end
    end

    // done flags the cycle whose edge performs the final step; product_o is that step's value.
    assign busy_o    = (cnt_q != '0);
    assign done_o    = (cnt_q == CW'(1));
    assign product_o = step;

endmodule

// File: rtl/stump_alu_seq.sv
// Registered Stump ALU with handshaked ops, internal NZVC flags and iterative MUL.
module stump_alu_seq
    import stump_alu_seq_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       func,
    input  logic [WIDTH-1:0] operand_A,
    input  logic [WIDTH-1:0] operand_B,
    input  logic             csh,
    input  logic             cc_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags_out
);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [3:0]           flags_q, flags_d;
    logic                 cc_q, cc_d;

    logic                 accept, is_mul, mul_start, mul_busy, mul_done;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH-1:0]     prod_lo, prod_hi;

    logic [WIDTH:0]       a_x, b_x, c_x, arith;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_v, alu_c, alu_sets;

    assign is_mul    = (MUL_EN != 0) && (func == FN_MUL);
    assign in_ready  = ((state_q == ST_IDLE) || (state_q == ST_DONE && out_ready)) && !mul_busy;
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && is_mul;
    assign prod_lo   = product[WIDTH-1:0];
    assign prod_hi   = product[2*WIDTH-1:WIDTH];

    stump_alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_start),
        .a_i       (operand_A),
        .b_i       (operand_B),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (product)
    );

    // Arithmetic on WIDTH+1 bits so the msb is carry (add) or borrow (subtract).
    always_comb begin
        a_x      = {1'b0, operand_A};
        b_x      = {1'b0, operand_B};
        c_x      = {{WIDTH{1'b0}}, flags_q[FLAG_C]};
        arith    = '0;
        alu_res  = '0;
        alu_v    = 1'b0;
        alu_c    = 1'b0;
        alu_sets = 1'b0;
        case (func)
            FN_ADD, FN_ADC: begin
                arith    = a_x + b_x + ((func == FN_ADC) ? c_x : '0);
                alu_res  = arith[WIDTH-1:0];
                alu_v    = (operand_A[WIDTH-1] == operand_B[WIDTH-1]) &&
                           (alu_res[WIDTH-1] != operand_A[WIDTH-1]);
                alu_c    = arith[WIDTH];
                alu_sets = 1'b1;
            end
            FN_SUB, FN_SBC: begin
                arith    = a_x - b_x - ((func == FN_SBC) ? c_x : '0);
                alu_res  = arith[WIDTH-1:0];
                alu_v    = (operand_A[WIDTH-1] != operand_B[WIDTH-1]) &&
                           (alu_res[WIDTH-1] == operand_B[WIDTH-1]);
                alu_c    = arith[WIDTH];
                alu_sets = 1'b1;
            end
            FN_AND: begin
                alu_res  = operand_A & operand_B;
                alu_c    = csh;
                alu_sets = 1'b1;
            end
            FN_OR: begin
                alu_res  = operand_A | operand_B;
                alu_c    = csh;
                alu_sets = 1'b1;
            end
            FN_LDST: alu_res = operand_B;
            FN_BCC:  alu_res = operand_A;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        cc_d     = cc_q;
        if (accept) begin
            cc_d = cc_en;
            if (is_mul) begin
                state_d = ST_MUL_RUN;
            end else begin
                state_d  = ST_DONE;
                result_d = alu_res;
                if (cc_en && alu_sets)
                    flags_d = {alu_res[WIDTH-1], (alu_res == '0), alu_v, alu_c};
            end
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_MUL_RUN: begin
                    if (mul_done) begin
                        state_d  = ST_DONE;
                        result_d = prod_lo;
                        if (cc_q)
                            flags_d = {prod_lo[WIDTH-1], (prod_lo == '0), (prod_hi != '0), 1'b0};
                    end
                end
                ST_DONE: begin
                    if (out_ready)
                        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            flags_q  <= '0;
            cc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            cc_q     <= cc_d;
        end
    end

    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign flags_out = flags_q;

endmodule

// File: tb/tb_stump_alu_seq.sv
// Directed self-checking bench for stump_alu_seq at WIDTH=16.
module tb_stump_alu_seq;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    func;
    logic [W-1:0]  operand_A;
    logic [W-1:0]  operand_B;
    logic          csh;
    logic          cc_en;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [3:0]    flags_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    stump_alu_seq #(.WIDTH(W), .MUL_EN(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .func      (func),
        .operand_A (operand_A),
        .operand_B (operand_B),
        .csh       (csh),
        .cc_en     (cc_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags_out (flags_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input logic cc);
        in_valid  = 1'b1;
        func      = f;
        operand_A = a;
        operand_B = b;
        csh       = c;
        cc_en     = cc;
    endtask

    // Issue one single-cycle op with out_ready=1, check latency-1 result, then retire it.
    task automatic single(input string tag, input logic [3:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic c, input logic cc,
                          input logic [W-1:0] exp_res, input logic [3:0] exp_flags);
        present(f, a, b, c, cc);
        check({tag, "_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_res"}, result, exp_res);
        check({tag, "_flags"}, flags_out, exp_flags);
        tick();
        check({tag, "_idle"}, out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic ready_seen;

        rst = 1'b1; in_valid = 1'b0; func = '0; operand_A = '0; operand_B = '0;
        csh = 1'b0; cc_en = 1'b0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_res", result, 0);
        check("rst_flags", flags_out, 0);
        check("rst_ready", in_ready, 1);

        single("add_ovf", 4'd0, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 4'b1010);
        single("sub_brw", 4'd2, 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 4'b1001);
        single("sub_nocc", 4'd2, 16'h0003, 16'h0005, 1'b0, 1'b0, 16'hFFFE, 4'b1001);
        single("ldst", 4'd6, 16'h1234, 16'hABCD, 1'b0, 1'b1, 16'hABCD, 4'b1001);
        single("bcc", 4'd7, 16'h1234, 16'hABCD, 1'b0, 1'b1, 16'h1234, 4'b1001);

        // Carry chain: ADD sets C, back-to-back ADC consumes it.
        present(4'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        tick();
        check("chain_add_res", result, 16'h0000);
        check("chain_add_flags", flags_out, 4'b0101);
        present(4'd1, 16'h0000, 16'h0000, 1'b0, 1'b1);
        check("chain_b2b_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("chain_adc_valid", out_valid, 1);
        check("chain_adc_res", result, 16'h0001);
        check("chain_adc_flags", flags_out, 4'b0000);
        tick();

        // MUL latency and in_ready blocking.
        present(4'd8, 16'h0100, 16'h0100, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        ready_seen = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) ready_seen = 1'b1;
            tick();
            lat++;
        end
        check("mul_latency", lat, 17);
        check("mul_ready_low", ready_seen, 0);
        check("mul_res", result, 16'h0000);
        check("mul_flags", flags_out, 4'b0110);
        tick();

        // Backpressure: result held while out_ready is low.
        out_ready = 1'b0;
        present(4'd4, 16'h00F0, 16'h0FF0, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", out_valid, 1);
            check("bp_res", result, 16'h00F0);
            check("bp_flags", flags_out, 4'b0001);
            check("bp_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        tick();
        check("bp_release_idle", out_valid, 0);

        // Reset five cycles into a MUL aborts it.
        present(4'd8, 16'h0003, 16'h0005, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_valid", out_valid, 0);
        check("mrst_res", result, 0);
        check("mrst_flags", flags_out, 0);
        check("mrst_ready", in_ready, 1);
        repeat (20) tick();
        check("mrst_no_late_done", out_valid, 0);

        single("post_add", 4'd0, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 4'b1010);
        single("reserved", 4'hA, 16'h1234, 16'h5678, 1'b1, 1'b1, 16'h0000, 4'b1010);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stump_alu_seq.md
Name: stump_alu_seq

Overview:
Parametrised, registered successor to the combinational Stump ALU. It sits between the register-file read stage and write-back. It executes the Stump function set plus an iterative multiply, holds the NZVC flags internally, and feeds ADC/SBC from its own C flag. Operations are accepted and returned through valid/ready handshakes, so multi-cycle ops can stall the datapath.

Parameters:
WIDTH, 16, operand/result width in bits (>=4)
MUL_EN, 1, 1 = MUL implemented; 0 = MUL decodes as reserved

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operation presented
in_ready  output  1  block can accept an operation this cycle
func  input  4  function code (0-7 as legacy Stump codes, 8 = MUL, 9-15 reserved)
operand_A  input  WIDTH  first operand
operand_B  input  WIDTH  second operand
csh  input  1  shifter carry, used as C for AND/OR
cc_en  input  1  update flags on completion
out_valid  output  1  result valid
out_ready  input  1  consumer takes result
result  output  WIDTH  registered result
flags_out  output  4  registered flags {N,Z,V,C}

Behaviour:
- Reset (rst high at a clk edge, any state, including mid-MUL): state IDLE; result=0; flags_out=4'b0000; out_valid=0; MUL aborts with no flag update.
- States: IDLE, MUL_RUN, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Accept = in_valid && in_ready; operands, func and cc_en are captured at accept.
- Ops 0-7 and reserved codes: accept edge -> DONE. out_valid is high in the next cycle (latency 1).
- MUL: accept -> MUL_RUN; counter loads WIDTH; one shift-add step per cycle; after WIDTH steps -> DONE. out_valid rises WIDTH+1 cycles after accept.
- DONE: result and out_valid held stable while out_ready=0. With out_ready=1: -> IDLE, or straight to the next op if in_valid (back-to-back, throughput 1/cycle for single-cycle ops).
- Arithmetic is computed on WIDTH+1 bits, with msb = carry out.
- ADD: A+B; C=carry out.
- ADC: A+B+Cflag; C=carry out.
- SUB: A-B; C=borrow (1 when A<B unsigned).
- SBC: A-B-Cflag; C=borrow.
- V for ADD/ADC: signed overflow (operands same sign, result sign differs).
- V for SUB/SBC: operand signs differ and result sign equals B's sign.
- AND, OR: V=0, C=csh.
- LDST: result=B. BCC: result=A. Neither touches flags.
- MUL: result = low WIDTH bits of the unsigned product; V=1 if the high WIDTH bits are nonzero; C=0.
- Reserved codes: result=0, flags untouched.
- N = result msb; Z = (result==0). This applies to every flag-setting op (0-5, 8).
- Flag register write happens on the edge entering DONE, only if captured cc_en=1 and the op is flag-setting. All four flags are written together; there are no partial or sticky updates.
- Cflag used by ADC/SBC is the flag register value at the accept edge. A back-to-back chained ADC therefore sees the prior op's carry.
- Cycle width rule: the MUL counter is $clog2(WIDTH+1) bits, and the product accumulator is 2*WIDTH bits.

Decomposition:
- Shared definitions include (extends Stump_definitions.v): func codes ADD..BCC, MUL, flag bit indices N=3/Z=2/V=1/C=0, state encodings.
- One sub-module, stump_alu_mul_iter: iterative shift-add multiplier with start/busy/done and the product output. The ALU top owns the FSM, the single-cycle datapath and the flags.

Test Plan (WIDTH=16):
- ADD 0x7FFF+0x0001, cc_en=1 -> result 0x8000, flags 4'b1010, out_valid 1 cycle after accept.
- SUB 0x0003-0x0005, cc_en=1 -> result 0xFFFE, flags 4'b1001. Repeat with cc_en=0 -> flags stay 4'b1001 from the prior op, unchanged.
- Carry chain: ADD 0xFFFF+0x0001 (flags 4'b0101), then back-to-back ADC 0x0000+0x0000 -> result 0x0001, flags 4'b0000.
- MUL 0x0100*0x0100 -> result 0x0000, flags 4'b0110, out_valid exactly 17 cycles after accept, in_ready=0 throughout MUL_RUN.
- Backpressure: AND 0x00F0&0x0FF0 with csh=1, out_ready=0 for 5 cycles -> result 0x00F0 held, flags 4'b0001, in_ready=0 until out_ready=1.
- rst asserted 5 cycles into MUL 0x0003*0x0005 -> next cycle IDLE, out_valid=0, result 0x0000, flags 4'b0000. A subsequent reserved func 0xA -> result 0x0000 with flags unchanged.
